// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_pkg
//  Description : Shared types and helpers for the IO register bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

    // Transaction phases: wait for a request, drive the bus, return the ack.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int IO_SIZE_DEFAULT = 16;

    // Word index of a byte address. Operates on a wide unsigned value so the
    // range compare never wraps for any address width up to 64 bits.
    function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : io_rr_pick
//  Description : Combinational round-robin picker. Scans last_gnt+1,
//                last_gnt+2, ... modulo NREQ and returns the first requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk the ring starting after the last grant; first hit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = last_gnt;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (req[cand] && !any) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_arbiter
//  Description : Round-robin arbiter sharing the IO register bus between NREQ
//                masters. Each transaction: one GRANT cycle driving the bus,
//                one ACK cycle returning read data / error to the master.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int IO_SIZE = IO_SIZE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          req_err,
    output logic [DATA_W-1:0]        req_rdata,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic                     bus_we,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic [DATA_W-1:0]        bus_rdata
);

    localparam int IDX_W = $clog2(NREQ);

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic [DATA_W-1:0]  rdata_q,    rdata_d;
    logic               err_q,      err_d;

    logic [NREQ-1:0]    gnt_onehot;
    logic [NREQ-1:0]    pick_mask;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;
    logic               bad;

    assign gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_q;

    // In ACK the granted master's request is stale, so hide it from the picker.
    assign pick_mask = (state_q == ACK) ? (req_i & ~gnt_onehot) : req_i;

    io_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (pick_mask),
        .last_gnt (last_gnt_q),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    // Select the granted master's address/data/direction.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx_q == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_we    = req_we[i];
            end
        end
    end

    // Misaligned or beyond the last IO word; compared at full word-index width.
    assign bad = (sel_addr[1:0] != 2'b00) ||
                 (word_index(64'(sel_addr)) >= 64'(IO_SIZE));

    // Bus is only driven during GRANT; bad accesses are squashed to zero.
    assign bus_we    = (state_q == GRANT) && sel_we && !bad;
    assign bus_addr  = ((state_q == GRANT) && !bad) ? sel_addr  : '0;
    assign bus_wdata = ((state_q == GRANT) && !bad) ? sel_wdata : '0;

    // Completion outputs only during ACK, steered to the granted master.
    assign req_ack   = (state_q == ACK) ? gnt_onehot : '0;
    assign req_err   = (state_q == ACK) ? (gnt_onehot & {NREQ{err_q}}) : '0;
    assign req_rdata = (state_q == ACK) ? rdata_q : '0;

    // Next-state logic: arbitrate in IDLE and ACK, capture result in GRANT.
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    gnt_idx_d  = pick_idx;
                    last_gnt_d = pick_idx;
                end
            end
            GRANT: begin
                rdata_d = bad ? '0 : bus_rdata;
                err_d   = bad;
                state_d = ACK;
            end
            ACK: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    gnt_idx_d  = pick_idx;
                    last_gnt_d = pick_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset points the ring so master 0 is scanned first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_gnt_q <= IDX_W'(NREQ - 1);
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_arbiter
//  Description : Directed self-checking bench for io_bus_arbiter (NREQ=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [63:0] req_addr;
    logic [1:0]  req_we;
    logic [63:0] req_wdata;
    logic [1:0]  req_ack;
    logic [1:0]  req_err;
    logic [31:0] req_rdata;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int checks;
    int errors;

    io_bus_arbiter #(
        .NREQ    (2),
        .ADDR_W  (32),
        .DATA_W  (32),
        .IO_SIZE (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".bus_we"},    {63'd0, bus_we}, 64'd0);
        chk({tag, ".bus_addr"},  {32'd0, bus_addr}, 64'd0);
        chk({tag, ".bus_wdata"}, {32'd0, bus_wdata}, 64'd0);
        chk({tag, ".ack"},       {62'd0, req_ack}, 64'd0);
        chk({tag, ".err"},       {62'd0, req_err}, 64'd0);
        chk({tag, ".rdata"},     {32'd0, req_rdata}, 64'd0);
    endtask

    logic prev_we;
    int   exp_m;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_i     = 2'b11;
        req_we    = 2'b01;
        req_addr  = {32'h0000_000C, 32'h0000_0004};
        req_wdata = {32'h0000_0AAA, 32'h0000_03FF};
        bus_rdata = 32'h0000_0155;

        // 1. Reset with all requests asserted: everything quiet.
        step();
        step();
        chk_quiet("reset");
        rst_n = 1'b1;

        // 2. Master 0 wins first, write 0x04 <= 0x3FF.
        step();
        chk("t2.bus_we",    {63'd0, bus_we}, 64'd1);
        chk("t2.bus_addr",  {32'd0, bus_addr}, 64'h04);
        chk("t2.bus_wdata", {32'd0, bus_wdata}, 64'h3FF);
        chk("t2.ack_g",     {62'd0, req_ack}, 64'd0);
        step();
        chk("t2.ack",       {62'd0, req_ack}, 64'b01);
        chk("t2.err",       {62'd0, req_err}, 64'd0);
        chk("t2.we_once",   {63'd0, bus_we}, 64'd0);
        req_i[0] = 1'b0;

        // 3. Master 1 read of 0x0C, back to back.
        step();
        chk("t3.bus_we",    {63'd0, bus_we}, 64'd0);
        chk("t3.bus_addr",  {32'd0, bus_addr}, 64'h0C);
        step();
        chk("t3.ack",       {62'd0, req_ack}, 64'b10);
        chk("t3.rdata",     {32'd0, req_rdata}, 64'h155);
        chk("t3.err",       {62'd0, req_err}, 64'd0);
        req_i = 2'b00;
        step();
        chk_quiet("t3.idle");

        // 4. Both masters write continuously: strict alternation.
        req_we    = 2'b11;
        req_addr  = {32'h0000_0010, 32'h0000_0008};
        req_wdata = {32'h0000_000B, 32'h0000_000A};
        req_i     = 2'b11;
        prev_we   = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            exp_m = (j / 2) % 2;
            if (j % 2 == 0) begin
                chk("t4.bus_we",   {63'd0, bus_we}, 64'd1);
                chk("t4.bus_addr", {32'd0, bus_addr}, (exp_m == 0) ? 64'h08 : 64'h10);
                chk("t4.ack_g",    {62'd0, req_ack}, 64'd0);
            end else begin
                chk("t4.ack",      {62'd0, req_ack}, (exp_m == 0) ? 64'b01 : 64'b10);
            end
            chk("t4.we_pair", {63'd0, prev_we & bus_we}, 64'd0);
            prev_we = bus_we;
        end
        req_i = 2'b00;
        step();
        chk_quiet("t4.idle");

        // 5. Misaligned then out-of-range writes from master 0.
        req_we    = 2'b01;
        req_addr  = {32'h0000_0000, 32'h0000_0006};
        req_wdata = {32'h0000_0000, 32'h0000_0055};
        bus_rdata = 32'h0000_0777;
        req_i     = 2'b01;
        step();
        chk("t5a.bus_we",   {63'd0, bus_we}, 64'd0);
        chk("t5a.bus_addr", {32'd0, bus_addr}, 64'd0);
        chk("t5a.bus_wdat", {32'd0, bus_wdata}, 64'd0);
        step();
        chk("t5a.ack",      {62'd0, req_ack}, 64'b01);
        chk("t5a.err",      {62'd0, req_err}, 64'b01);
        chk("t5a.rdata",    {32'd0, req_rdata}, 64'd0);
        req_addr[31:0] = 32'h0000_0040;
        step();
        chk("t5.gap_ack",   {62'd0, req_ack}, 64'd0);
        step();
        chk("t5b.bus_we",   {63'd0, bus_we}, 64'd0);
        chk("t5b.bus_addr", {32'd0, bus_addr}, 64'd0);
        step();
        chk("t5b.ack",      {62'd0, req_ack}, 64'b01);
        chk("t5b.err",      {62'd0, req_err}, 64'b01);
        chk("t5b.rdata",    {32'd0, req_rdata}, 64'd0);
        req_i = 2'b00;
        step();

        // 6. Reset mid-GRANT of a write, then the held request is replayed.
        req_addr  = {32'h0000_0000, 32'h0000_0008};
        req_wdata = {32'h0000_0000, 32'h0000_0123};
        req_i     = 2'b01;
        step();
        chk("t6.bus_we_pre", {63'd0, bus_we}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.we_drop",   {63'd0, bus_we}, 64'd0);
        step();
        chk("t6.no_ack",    {62'd0, req_ack}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("t6.re_we",     {63'd0, bus_we}, 64'd1);
        chk("t6.re_addr",   {32'd0, bus_addr}, 64'h08);
        chk("t6.re_wdata",  {32'd0, bus_wdata}, 64'h123);
        step();
        chk("t6.re_ack",    {62'd0, req_ack}, 64'b01);
        chk("t6.re_err",    {62'd0, req_err}, 64'd0);
        req_i = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
